// File: rtl/sdram_init_monitor_pkg.sv
// Shared SDRAM command codes, monitor error codes and state encodings.
package sdram_init_monitor_pkg;

    // {CS_n, RAS_n, CAS_n, WE_n}
    localparam logic [3:0] OP_LOAD_MR    = 4'b0000;
    localparam logic [3:0] OP_AUTO_REF   = 4'b0001;
    localparam logic [3:0] OP_PRECHARGE  = 4'b0010;
    localparam logic [3:0] OP_ACTIVE     = 4'b0011;
    localparam logic [3:0] OP_WRITE      = 4'b0100;
    localparam logic [3:0] OP_READ       = 4'b0101;
    localparam logic [3:0] OP_BURST_STOP = 4'b0110;
    localparam logic [3:0] OP_NOP        = 4'b0111;

    localparam logic [2:0] ERR_NONE         = 3'd0;
    localparam logic [2:0] ERR_EARLY_CMD    = 3'd1;
    localparam logic [2:0] ERR_BAD_ORDER    = 3'd2;
    localparam logic [2:0] ERR_TRP_VIOL     = 3'd3;
    localparam logic [2:0] ERR_TRFC_VIOL    = 3'd4;
    localparam logic [2:0] ERR_TMRD_VIOL    = 3'd5;
    localparam logic [2:0] ERR_BAD_MR       = 3'd6;
    localparam logic [2:0] ERR_REF_OVERFLOW = 3'd7;

    localparam int unsigned CNT_W   = 8;
    localparam logic [2:0]  REF_MAX = 3'd7;

    typedef enum logic [2:0] {
        ST_POWERUP  = 3'd0,
        ST_TRP_WAIT = 3'd1,
        ST_REF_WAIT = 3'd2,
        ST_MR_WAIT  = 3'd3,
        ST_DONE     = 3'd4,
        ST_ERROR    = 3'd5
    } mon_state_e;

    // A deselected device (CS_n high) sees the same thing as an explicit NOP.
    function automatic logic cmd_is_nop(input logic [3:0] cmd);
        return cmd[3] || (cmd == OP_NOP);
    endfunction

endpackage

// File: rtl/sdram_mr_decode.sv
// Combinational mode-register decode: CAS latency, burst length and legality.
module sdram_mr_decode
    import sdram_init_monitor_pkg::*;
(
    input  logic [1:0]  ba,
    input  logic [12:0] addr,
    output logic [2:0]  cas_latency,
    output logic [3:0]  burst_length,
    output logic        mr_ok
);

    logic cl_ok;
    logic bl_ok;
    logic unused_mr_bits;

    // Burst type and the upper address bits carry no checked information.
    assign unused_mr_bits = ^{addr[12:9], addr[3]};

    // Decode CL from A6:A4 and BL from A2:A0; reserved fields make the MR illegal.
    always_comb begin
        cas_latency  = 3'd0;
        burst_length = 4'd0;
        cl_ok        = 1'b0;
        bl_ok        = 1'b0;
        case (addr[6:4])
            3'b001:  begin cas_latency = 3'd1; cl_ok = 1'b1; end
            3'b010:  begin cas_latency = 3'd2; cl_ok = 1'b1; end
            3'b011:  begin cas_latency = 3'd3; cl_ok = 1'b1; end
            default: ;
        endcase
        case (addr[2:0])
            3'b000:  begin burst_length = 4'd1; bl_ok = 1'b1; end
            3'b001:  begin burst_length = 4'd2; bl_ok = 1'b1; end
            3'b010:  begin burst_length = 4'd4; bl_ok = 1'b1; end
            3'b011:  begin burst_length = 4'd8; bl_ok = 1'b1; end
            default: ;
        endcase
        mr_ok = (ba == 2'b00) && (addr[8:7] == 2'b00) && cl_ok && bl_ok;
    end

endmodule

// File: rtl/sdram_init_monitor.sv
// SDRAM power-up sequence checker: order, tPowerUp/tRP/tRFC/tMRD and MR decode.
module sdram_init_monitor
    import sdram_init_monitor_pkg::*;
#(
    parameter int unsigned CLK              = 100_000_000,
    parameter int unsigned TPOWERUP         = 200,
    parameter int unsigned TRP              = 20,
    parameter int unsigned TRFC             = 70,
    parameter int unsigned TMRD             = 2,
    parameter logic [2:0]  MIN_AUTO_REFRESH = 3'd2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  cmd,
    input  logic [1:0]  ba,
    input  logic [12:0] addr,
    output logic        init_done,
    output logic        err,
    output logic [2:0]  err_code,
    output logic [2:0]  ref_count,
    output logic [2:0]  cas_latency,
    output logic [3:0]  burst_length,
    output logic        mr_valid
);

    localparam int unsigned TIME_PER_CLK = 1_000_000_000 / CLK;
    localparam int unsigned CLK_POWER_UP = TPOWERUP / TIME_PER_CLK;
    localparam int unsigned CLK_TRP      = TRP / TIME_PER_CLK;
    localparam int unsigned CLK_TRFC     = TRFC / TIME_PER_CLK;

    mon_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       ref_count_q, ref_count_d;
    logic             init_done_q, init_done_d;
    logic             err_q, err_d;
    logic [2:0]       err_code_q, err_code_d;
    logic [2:0]       cas_latency_q, cas_latency_d;
    logic [3:0]       burst_length_q, burst_length_d;
    logic             mr_valid_q, mr_valid_d;

    logic [2:0]  dec_cl;
    logic [3:0]  dec_bl;
    logic        dec_ok;
    logic        nop;
    logic        fail;
    logic [2:0]  fail_code;
    logic        accept;
    logic [31:0] elapsed;

    sdram_mr_decode u_mr_decode (
        .ba           (ba),
        .addr         (addr),
        .cas_latency  (dec_cl),
        .burst_length (dec_bl),
        .mr_ok        (dec_ok)
    );

    // Next-state, gap counter and registered-output computation.
    always_comb begin
        state_d        = state_q;
        cnt_d          = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
        ref_count_d    = ref_count_q;
        init_done_d    = init_done_q;
        err_d          = err_q;
        err_code_d     = err_code_q;
        cas_latency_d  = cas_latency_q;
        burst_length_d = burst_length_q;
        mr_valid_d     = mr_valid_q;
        fail           = 1'b0;
        fail_code      = ERR_NONE;
        accept         = 1'b0;
        nop            = cmd_is_nop(cmd);
        // Cycles since the previous accepted command (or reset release).
        elapsed        = 32'(cnt_q) + 32'd1;

        case (state_q)
            ST_POWERUP: begin
                if (!nop) begin
                    if (elapsed < CLK_POWER_UP) begin
                        fail = 1'b1; fail_code = ERR_EARLY_CMD;
                    end else if (cmd == OP_PRECHARGE && addr[10]) begin
                        accept = 1'b1; state_d = ST_TRP_WAIT;
                    end else begin
                        fail = 1'b1; fail_code = ERR_BAD_ORDER;
                    end
                end
            end
            ST_TRP_WAIT: begin
                if (!nop) begin
                    if (elapsed < CLK_TRP) begin
                        fail = 1'b1; fail_code = ERR_TRP_VIOL;
                    end else if (cmd == OP_AUTO_REF) begin
                        accept = 1'b1; ref_count_d = 3'd1; state_d = ST_REF_WAIT;
                    end else begin
                        fail = 1'b1; fail_code = ERR_BAD_ORDER;
                    end
                end
            end
            ST_REF_WAIT: begin
                if (!nop) begin
                    if (elapsed < CLK_TRFC) begin
                        fail = 1'b1; fail_code = ERR_TRFC_VIOL;
                    end else if (cmd == OP_AUTO_REF) begin
                        if (ref_count_q == REF_MAX) begin
                            fail = 1'b1; fail_code = ERR_REF_OVERFLOW;
                        end else begin
                            accept = 1'b1; ref_count_d = ref_count_q + 3'd1;
                        end
                    end else if (cmd == OP_LOAD_MR) begin
                        if (ref_count_q < MIN_AUTO_REFRESH) begin
                            fail = 1'b1; fail_code = ERR_BAD_ORDER;
                        end else if (!dec_ok) begin
                            fail = 1'b1; fail_code = ERR_BAD_MR;
                        end else begin
                            accept         = 1'b1;
                            state_d        = ST_MR_WAIT;
                            cas_latency_d  = dec_cl;
                            burst_length_d = dec_bl;
                            mr_valid_d     = 1'b1;
                        end
                    end else begin
                        fail = 1'b1; fail_code = ERR_BAD_ORDER;
                    end
                end
            end
            ST_MR_WAIT: begin
                if (!nop && elapsed < TMRD) begin
                    fail = 1'b1; fail_code = ERR_TMRD_VIOL;
                end else if (!nop && cmd != OP_PRECHARGE && cmd != OP_AUTO_REF &&
                             cmd != OP_LOAD_MR) begin
                    fail = 1'b1; fail_code = ERR_BAD_ORDER;
                end else if (elapsed >= TMRD) begin
                    state_d     = ST_DONE;
                    init_done_d = 1'b1;
                end
            end
            ST_DONE:  ;
            ST_ERROR: ;
            default: begin
                state_d = ST_ERROR;
            end
        endcase

        if (accept) begin
            cnt_d = '0;
        end
        if (fail) begin
            state_d     = ST_ERROR;
            err_d       = 1'b1;
            init_done_d = 1'b0;
            if (!err_q) begin
                err_code_d = fail_code;
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_POWERUP;
            cnt_q          <= '0;
            ref_count_q    <= 3'd0;
            init_done_q    <= 1'b0;
            err_q          <= 1'b0;
            err_code_q     <= ERR_NONE;
            cas_latency_q  <= 3'd0;
            burst_length_q <= 4'd0;
            mr_valid_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            ref_count_q    <= ref_count_d;
            init_done_q    <= init_done_d;
            err_q          <= err_d;
            err_code_q     <= err_code_d;
            cas_latency_q  <= cas_latency_d;
            burst_length_q <= burst_length_d;
            mr_valid_q     <= mr_valid_d;
        end
    end

    assign init_done    = init_done_q;
    assign err          = err_q;
    assign err_code     = err_code_q;
    assign ref_count    = ref_count_q;
    assign cas_latency  = cas_latency_q;
    assign burst_length = burst_length_q;
    assign mr_valid     = mr_valid_q;

endmodule
